// File: rtl/awgn_stats_rx.sv
// awgn_stats_rx: windowed mean / mean-power statistics for paired AWGN samples.
// Accepts 2^LOG2_N (x0, x1) pairs over valid/ready, then reports per-channel
// floor means and floor mean-squares over a valid/ack handshake.
// Optional build macro AWGN_STATS_CLIP_EN adds per-channel full-scale sample counts.
module awgn_stats_rx #(
  parameter int unsigned LOG2_N = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        x0,
  input  logic [15:0]        x1,
  output logic               stat_valid,
  input  logic               stat_ack,
  output logic [15:0]        mean0,
  output logic [15:0]        mean1,
  output logic [31:0]        pwr0,
  output logic [31:0]        pwr1,
`ifdef AWGN_STATS_CLIP_EN
  output logic [LOG2_N:0]    clip0,
  output logic [LOG2_N:0]    clip1,
`endif
  output logic               busy
);

  localparam int unsigned SW = 16 + LOG2_N;
  localparam int unsigned QW = 31 + LOG2_N;
  localparam int unsigned CW = LOG2_N + 1;
  localparam int unsigned N  = 1 << LOG2_N;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pv_q, pv_d;
  logic [15:0]          x0p_q, x0p_d, x1p_q, x1p_d;
  logic [30:0]          sq0p_q, sq0p_d, sq1p_q, sq1p_d;
  logic signed [SW-1:0] sum0_q, sum0_d, sum1_q, sum1_d;
  logic [QW-1:0]        sqa0_q, sqa0_d, sqa1_q, sqa1_d;
  logic                 in_ready_q, in_ready_d;
  logic                 stat_valid_q, stat_valid_d;
  logic                 busy_q, busy_d;
  logic [15:0]          mean0_q, mean0_d, mean1_q, mean1_d;
  logic [31:0]          pwr0_q, pwr0_d, pwr1_q, pwr1_d;
`ifdef AWGN_STATS_CLIP_EN
  logic [CW-1:0]        ccnt0_q, ccnt0_d, ccnt1_q, ccnt1_d;
  logic [CW-1:0]        clip0_q, clip0_d, clip1_q, clip1_d;
`endif

  logic                 xfer_c;
  logic                 clear_c;
  logic signed [30:0]   x0e_c, x1e_c;

  // Sign-extended samples so the square is formed exactly, including (-32768)^2.
  always_comb begin
    x0e_c = {{15{x0[15]}}, x0};
    x1e_c = {{15{x1[15]}}, x1};
  end

  // Next-state, product stage, accumulation and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pv_d       = 1'b0;
    x0p_d      = x0p_q;
    x1p_d      = x1p_q;
    sq0p_d     = sq0p_q;
    sq1p_d     = sq1p_q;
    sum0_d     = sum0_q;
    sum1_d     = sum1_q;
    sqa0_d     = sqa0_q;
    sqa1_d     = sqa1_q;
    mean0_d    = mean0_q;
    mean1_d    = mean1_q;
    pwr0_d     = pwr0_q;
    pwr1_d     = pwr1_q;
`ifdef AWGN_STATS_CLIP_EN
    ccnt0_d    = ccnt0_q;
    ccnt1_d    = ccnt1_q;
    clip0_d    = clip0_q;
    clip1_d    = clip1_q;
`endif
    clear_c    = 1'b0;
    xfer_c     = in_ready_q & in_valid;

    // Product stage: capture the pair and its squares on every transfer.
    if (xfer_c) begin
      pv_d   = 1'b1;
      x0p_d  = x0;
      x1p_d  = x1;
      sq0p_d = 31'(x0e_c * x0e_c);
      sq1p_d = 31'(x1e_c * x1e_c);
    end

    // Accumulate the previous transfer's products.
    if (pv_q) begin
      sum0_d = sum0_q + SW'($signed(x0p_q));
      sum1_d = sum1_q + SW'($signed(x1p_q));
      sqa0_d = sqa0_q + QW'(sq0p_q);
      sqa1_d = sqa1_q + QW'(sq1p_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          clear_c = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (xfer_c) begin
          cnt_d = cnt_q + CW'(1);
`ifdef AWGN_STATS_CLIP_EN
          if (x0 == 16'h7FFF || x0 == 16'h8000) ccnt0_d = ccnt0_q + CW'(1);
          if (x1 == 16'h7FFF || x1 == 16'h8000) ccnt1_d = ccnt1_q + CW'(1);
`endif
          if (cnt_q == CW'(N - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Leave once the final product has been folded into the accumulators.
        if (!pv_q) begin
          state_d = ST_REPORT;
          mean0_d = 16'(sum0_q >>> LOG2_N);
          mean1_d = 16'(sum1_q >>> LOG2_N);
          pwr0_d  = 32'(sqa0_q >> LOG2_N);
          pwr1_d  = 32'(sqa1_q >> LOG2_N);
`ifdef AWGN_STATS_CLIP_EN
          clip0_d = ccnt0_q;
          clip1_d = ccnt1_q;
`endif
        end
      end
      ST_REPORT: begin
        if (stat_ack) begin
          if (start) begin
            state_d = ST_ACCUM;
            clear_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new window starts from empty accumulators.
    if (clear_c) begin
      cnt_d  = '0;
      pv_d   = 1'b0;
      sum0_d = '0;
      sum1_d = '0;
      sqa0_d = '0;
      sqa1_d = '0;
`ifdef AWGN_STATS_CLIP_EN
      ccnt0_d = '0;
      ccnt1_d = '0;
`endif
    end

    in_ready_d   = (state_d == ST_ACCUM);
    stat_valid_d = (state_d == ST_REPORT);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pv_q         <= 1'b0;
      x0p_q        <= '0;
      x1p_q        <= '0;
      sq0p_q       <= '0;
      sq1p_q       <= '0;
      sum0_q       <= '0;
      sum1_q       <= '0;
      sqa0_q       <= '0;
      sqa1_q       <= '0;
      in_ready_q   <= 1'b0;
      stat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      mean0_q      <= '0;
      mean1_q      <= '0;
      pwr0_q       <= '0;
      pwr1_q       <= '0;
`ifdef AWGN_STATS_CLIP_EN
      ccnt0_q      <= '0;
      ccnt1_q      <= '0;
      clip0_q      <= '0;
      clip1_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pv_q         <= pv_d;
      x0p_q        <= x0p_d;
      x1p_q        <= x1p_d;
      sq0p_q       <= sq0p_d;
      sq1p_q       <= sq1p_d;
      sum0_q       <= sum0_d;
      sum1_q       <= sum1_d;
      sqa0_q       <= sqa0_d;
      sqa1_q       <= sqa1_d;
      in_ready_q   <= in_ready_d;
      stat_valid_q <= stat_valid_d;
      busy_q       <= busy_d;
      mean0_q      <= mean0_d;
      mean1_q      <= mean1_d;
      pwr0_q       <= pwr0_d;
      pwr1_q       <= pwr1_d;
`ifdef AWGN_STATS_CLIP_EN
      ccnt0_q      <= ccnt0_d;
      ccnt1_q      <= ccnt1_d;
      clip0_q      <= clip0_d;
      clip1_q      <= clip1_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign stat_valid = stat_valid_q;
  assign busy       = busy_q;
  assign mean0      = mean0_q;
  assign mean1      = mean1_q;
  assign pwr0       = pwr0_q;
  assign pwr1       = pwr1_q;
`ifdef AWGN_STATS_CLIP_EN
  assign clip0      = clip0_q;
  assign clip1      = clip1_q;
`endif

endmodule

// File: tb/tb_awgn_stats_rx.sv
// Testbench for awgn_stats_rx with LOG2_N=2: directed windows, scoreboard of
// expected reports computed from the driven samples, timing and reset checks.
module tb_awgn_stats_rx;

  localparam int unsigned L = 2;
  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x0 = '0;
  logic [15:0] x1 = '0;
  logic        stat_valid;
  logic        stat_ack = 1'b0;
  logic [15:0] mean0, mean1;
  logic [31:0] pwr0, pwr1;
  logic        busy;
`ifdef AWGN_STATS_CLIP_EN
  logic [L:0]  clip0, clip1;
`endif

  awgn_stats_rx #(.LOG2_N(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x0         (x0),
    .x1         (x1),
    .stat_valid (stat_valid),
    .stat_ack   (stat_ack),
    .mean0      (mean0),
    .mean1      (mean1),
    .pwr0       (pwr0),
    .pwr1       (pwr1),
`ifdef AWGN_STATS_CLIP_EN
    .clip0      (clip0),
    .clip1      (clip1),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] m0;
    logic [15:0] m1;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [L:0]  c0;
    logic [L:0]  c1;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_e;
  logic [15:0] d0[N];
  logic [15:0] d1[N];
  int          total = 0;
  int          passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference statistics of the loaded window, pushed to the scoreboard.
  task automatic push_expected();
    exp_t   e;
    int     s0, s1;
    longint q0, q1;
    int     v0, v1;
    s0 = 0; s1 = 0; q0 = 0; q1 = 0;
    e.c0 = '0; e.c1 = '0;
    for (int i = 0; i < int'(N); i++) begin
      v0 = int'($signed(d0[i]));
      v1 = int'($signed(d1[i]));
      s0 = s0 + v0;
      s1 = s1 + v1;
      q0 = q0 + longint'(v0) * longint'(v0);
      q1 = q1 + longint'(v1) * longint'(v1);
      if (d0[i] == 16'h7FFF || d0[i] == 16'h8000) e.c0 = e.c0 + 1'b1;
      if (d1[i] == 16'h7FFF || d1[i] == 16'h8000) e.c1 = e.c1 + 1'b1;
    end
    e.m0 = 16'(s0 >>> L);
    e.m1 = 16'(s1 >>> L);
    e.p0 = 32'(q0 >> L);
    e.p1 = 32'(q1 >> L);
    sb.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Offer pair i until it transfers, then idle in_valid for gap cycles.
  task automatic send_pair(input int i, input int gap, input bit mid_start);
    int b;
    in_valid = 1'b1;
    x0 = d0[i];
    x1 = d1[i];
    b = 0;
    while (!in_ready && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
    if (mid_start) start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    x0 = 16'($urandom);
    x1 = 16'($urandom);
    repeat (gap) tick();
  endtask

  task automatic run_window(input int gap, input int mid_idx);
    exp_t e;
    push_expected();
    for (int i = 0; i < int'(N); i++)
      send_pair(i, (i == int'(N) - 1) ? 0 : gap, (i == mid_idx));
    // Extra offers during flush/report must be refused.
    in_valid = 1'b1;
    x0 = 16'h7FFF;
    x1 = 16'h1234;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_stat_valid", 32'(stat_valid), 32'd0);
    tick();
    chk("flush2_stat_valid", 32'(stat_valid), 32'd0);
    chk("flush2_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("report_stat_valid", 32'(stat_valid), 32'd1);
    chk("report_in_ready", 32'(in_ready), 32'd0);
    chk("report_busy", 32'(busy), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      last_e = e;
      chk("mean0", 32'(mean0), 32'(e.m0));
      chk("mean1", 32'(mean1), 32'(e.m1));
      chk("pwr0", pwr0, e.p0);
      chk("pwr1", pwr1, e.p1);
`ifdef AWGN_STATS_CLIP_EN
      chk("clip0", 32'(clip0), 32'(e.c0));
      chk("clip1", 32'(clip1), 32'(e.c1));
`endif
    end
    tick();
    in_valid = 1'b0;
    chk("report_held", 32'(stat_valid), 32'd1);
    chk("report_mean0_stable", 32'(mean0), 32'(last_e.m0));
  endtask

  task automatic do_ack(input bit b2b);
    stat_ack = 1'b1;
    start = b2b;
    tick();
    stat_ack = 1'b0;
    start = 1'b0;
    chk("ack_stat_valid", 32'(stat_valid), 32'd0);
    chk("ack_in_ready", 32'(in_ready), 32'(b2b));
    chk("ack_busy", 32'(busy), 32'(b2b));
    chk("ack_mean0_kept", 32'(mean0), 32'(last_e.m0));
    chk("ack_pwr1_kept", pwr1, last_e.p1);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stat_valid", 32'(stat_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mean0", 32'(mean0), 32'd0);
    chk("rst_pwr0", pwr0, 32'd0);
    #4 reset = 1'b1;
    tick();

    // Window 1: mixed values, floor of negative mean
    d0[0] = 16'd100; d0[1] = 16'd200; d0[2] = 16'd300; d0[3] = 16'd400;
    d1[0] = 16'hFFFF; d1[1] = 16'hFFFF; d1[2] = 16'hFFFF; d1[3] = 16'hFFFE;
    do_start();
    run_window(0, -1);
    do_ack(1'b0);

    // Window 2: all full-scale negative
    for (int i = 0; i < int'(N); i++) begin
      d0[i] = 16'h8000;
      d1[i] = 16'h8000;
    end
    do_start();
    run_window(0, -1);
    do_ack(1'b0);

    // Window 3: toggling in_valid, then back-to-back into window 4
    d0[0] = 16'd100; d0[1] = 16'd200; d0[2] = 16'd300; d0[3] = 16'd400;
    d1[0] = 16'hFFFF; d1[1] = 16'hFFFF; d1[2] = 16'hFFFF; d1[3] = 16'hFFFE;
    do_start();
    run_window(1, -1);
    do_ack(1'b1);

    // Window 4: random data, already in ACCUM
    for (int i = 0; i < int'(N); i++) begin
      d0[i] = 16'($urandom);
      d1[i] = 16'($urandom);
    end
    d0[2] = 16'h7FFF;
    run_window(0, -1);
    do_ack(1'b0);

    // Abort a window with reset after two transfers
    d0[0] = 16'd30000; d0[1] = 16'd30000; d0[2] = 16'd30000; d0[3] = 16'd30000;
    d1[0] = 16'd5; d1[1] = 16'd5; d1[2] = 16'd5; d1[3] = 16'd5;
    do_start();
    send_pair(0, 0, 1'b0);
    send_pair(1, 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mean0", 32'(mean0), 32'd0);
    chk("abort_pwr1", pwr1, 32'd0);
    #3 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_report", 32'(stat_valid), 32'd0);
    end
    d0[0] = 16'hFFF6; d0[1] = 16'd3; d0[2] = 16'd0; d0[3] = 16'd1;
    d1[0] = 16'd7; d1[1] = 16'h8000; d1[2] = 16'h7FFF; d1[3] = 16'd2;
    do_start();
    run_window(0, -1);
    do_ack(1'b0);

    // Start pulsed mid-window has no effect
    d0[0] = 16'd1; d0[1] = 16'd2; d0[2] = 16'd3; d0[3] = 16'd5;
    d1[0] = 16'hFFF0; d1[1] = 16'd16; d1[2] = 16'hFFF0; d1[3] = 16'd15;
    do_start();
    run_window(0, 1);
    do_ack(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
